deshift_buf: RTL and testbench
==============================

# deshift_buf

Read-side counterpart of the byte-skewing shift buffer. It accepts row-aligned WIDTH-lane beats and writes every lane at the same address. It then drains the stored frame, reading each lane at a per-lane skewed address, which undoes a diagonal/transposed layout. It sits between the systolic-array output collector and the global buffer writer, and restores channel-major order from the array's skewed result stream.

## Interface
- DATA_WIDTH, 8, bits per lane element
- WIDTH, 32, lanes per beat
- ADDR_WIDTH, 8, per-lane buffer address width
- DEPTH, 2**ADDR_WIDTH, words per lane
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- Rst  in  1  synchronous clear; returns the block to IN
- ByteRdIncr  in  1  1: lane address increments with wrap at M; 0: lane address decrements modulo DEPTH
- ByteRdStep  in  ADDR_WIDTH  address step between adjacent lanes
- RdBackStep  in  ADDR_WIDTH  wrap span in steps; M = ByteRdStep*RdBackStep
- din  in  WIDTH*DATA_WIDTH  input beat, lane i = din[i]
- din_vld / din_last / din_rdy  in/in/out  1 each  input handshake; last marks final beat of frame
- dout  out  WIDTH*DATA_WIDTH  de-skewed output beat
- dout_vld / dout_last / dout_rdy  out/out/in  1 each  output handshake
- word_count  out  ADDR_WIDTH+1  words currently held

## Operation
- States: IN (fill), OUT (drain). Reset state is IN.
- IN: din_rdy=1. On din_vld&din_rdy, all lanes are written at wr_ptr and wr_ptr increments. A handshake carrying din_last, or a write at wr_ptr==DEPTH-1, latches total=wr_ptr+1 and moves to OUT next cycle.
- OUT: din_rdy=0. Reads are issued for rd_ptr = 0..total-1. Lane i address:
  - ByteRdIncr=1: (rd_ptr + ByteRdStep*i) mod M.
  - ByteRdIncr=0: (rd_ptr − ByteRdStep*i) mod DEPTH.
- Products are computed at 2*ADDR_WIDTH bits before reduction. M==0 or M>DEPTH is treated as M=DEPTH.
- dout_last is asserted with the beat for rd_ptr=total-1. That beat's handshake clears both pointers and returns to IN.
- word_count: +1 per accepted input beat, −1 per output handshake. It is never incremented and decremented in the same cycle, because IN and OUT are exclusive.
- Rst has priority over every other event: pointers and word_count go to 0, the output register is invalidated, and the state goes to IN in the same edge.

## Timing
- Reset values: din_rdy=1, dout_vld=0, dout_last=0, dout=0, word_count=0.
- RAM read latency is 1 cycle; the output stage is a 2-entry skid buffer.
- First dout_vld is asserted 2 cycles after the last-write edge.
- Throughput is 1 beat/cycle while dout_rdy=1.
- dout/dout_vld/dout_last stay stable while dout_vld&!dout_rdy.
- Reads stop issuing when the skid buffer is full; no data is dropped.
- The first IN write can occur on the cycle after the final output handshake.
- rst_n assertion mid-frame discards all stored data immediately. RAM contents are undefined and never read.

## Configuration
- DESHIFT_ZPAD_EN defined: a lane whose computed address is ≥ total outputs 0.
- Undefined: that lane outputs raw RAM contents.

## Structure
- deshift_pkg: state enum {IN, OUT}, and a localparam for the 2*ADDR_WIDTH product width.
- Sub-module deshift_lane_addr: per-lane address and zero-pad flag, combinational, instantiated WIDTH times.
- Storage: WIDTH instances of the existing dual-port RAM_HS, DATA_WIDTH x DEPTH each.

## Test plan
- Incr mode: WIDTH=4, ByteRdStep=1, RdBackStep=4, 4 beats with din[i]=16*beat+i. Required: beat r, lane i = 16*((r+i)%4)+i; dout_last on beat 3.
- Decrement mode, ByteRdStep=1, 8 beats, DESHIFT_ZPAD_EN defined. Required: lanes whose address wraps below 0 output 0; all other lanes match the stored value at rd_ptr−i.
- Backpressure: dout_rdy toggles 1,0,0,1 throughout the drain. Required: no duplicated or lost beats; dout stable while stalled; word_count reaches 0 after the last beat.
- Overflow: DEPTH words written with no din_last. Required: state goes to OUT after write DEPTH-1; din_rdy=0; DEPTH output beats.
- Rst asserted mid-drain at rd_ptr=3. Required: next cycle dout_vld=0, word_count=0, din_rdy=1; a new frame then reads back correctly.
- rst_n pulsed during fill. Required: all outputs at reset values; a subsequent 2-beat frame produces exactly 2 outputs.

Source files
------------

// File: rtl/deshift_pkg.sv
// deshift_pkg: shared types and sizing helpers for the de-skewing read buffer.
package deshift_pkg;

  // Fill/drain phases of the buffer.
  typedef enum logic {
    ST_IN  = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  // Address products are formed at twice the address width before reduction.
  localparam int PROD_MULT = 2;

  function automatic int prod_width(input int aw);
    return PROD_MULT * aw;
  endfunction

endpackage

// File: rtl/RAM_HS.sv
// RAM_HS: simple dual-port RAM, one write port and one registered read port.
module RAM_HS #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/deshift_lane_addr.sv
// deshift_lane_addr: skewed read address and zero-pad flag for one lane.
// Forward mode wraps at M = step*back_step (M==0 or M>DEPTH means DEPTH);
// backward mode wraps modulo DEPTH.
module deshift_lane_addr
  import deshift_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int LANE       = 0
) (
  input  logic                  incr_i,
  input  logic [ADDR_WIDTH-1:0] rd_ptr_i,
  input  logic [ADDR_WIDTH-1:0] step_i,
  input  logic [ADDR_WIDTH-1:0] back_i,
  input  logic [ADDR_WIDTH:0]   total_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  zpad_o
);

  localparam int PW = prod_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LANE_P  = PW'(LANE);

  logic [PW-1:0] offset;
  logic [PW-1:0] span;
  logic [PW-1:0] span_eff;
  logic [PW:0]   sum;

  assign offset   = PW'(step_i) * LANE_P;
  assign span     = PW'(step_i) * PW'(back_i);
  assign span_eff = ((span == '0) || (span > DEPTH_P)) ? DEPTH_P : span;
  assign sum      = {1'b0, PW'(rd_ptr_i)} + {1'b0, offset};

  // DEPTH is a power of two, so the backward wrap is plain truncation.
  assign addr_o = incr_i ? ADDR_WIDTH'(sum % {1'b0, span_eff})
                         : (rd_ptr_i - ADDR_WIDTH'(offset));
  assign zpad_o = ({1'b0, addr_o} >= total_i);

endmodule

// File: rtl/deshift_buf.sv
// deshift_buf: fills a frame with every lane at the same address, then drains
// it with per-lane skewed read addresses to undo the diagonal layout.
// Optional feature macro DESHIFT_ZPAD_EN: lanes whose read address is beyond
// the stored frame output zero instead of raw RAM contents.
module deshift_buf
  import deshift_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Rst,
  input  logic                        ByteRdIncr,
  input  logic [ADDR_WIDTH-1:0]       ByteRdStep,
  input  logic [ADDR_WIDTH-1:0]       RdBackStep,
  input  logic [WIDTH*DATA_WIDTH-1:0] din,
  input  logic                        din_vld,
  input  logic                        din_last,
  output logic                        din_rdy,
  output logic [WIDTH*DATA_WIDTH-1:0] dout,
  output logic                        dout_vld,
  output logic                        dout_last,
  input  logic                        dout_rdy,
  output logic [ADDR_WIDTH:0]         word_count
);

`ifdef DESHIFT_ZPAD_EN
  localparam bit ZPAD_EN = 1'b1;
`else
  localparam bit ZPAD_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_W = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);

  state_t                      state_q;
  logic [ADDR_WIDTH-1:0]       wr_ptr_q;
  logic [ADDR_WIDTH:0]         rd_ptr_q;
  logic [ADDR_WIDTH:0]         total_q;
  logic [ADDR_WIDTH:0]         word_count_q;
  logic                        rd_vld_q;
  logic                        rd_last_q;
  logic [WIDTH-1:0]            zpad_q;
  logic [WIDTH-1:0]            zpad_d;
  logic [1:0]                  cnt_q;
  logic [WIDTH*DATA_WIDTH-1:0] head_data_q;
  logic                        head_last_q;
  logic [WIDTH*DATA_WIDTH-1:0] tail_data_q;
  logic                        tail_last_q;
  logic [WIDTH*DATA_WIDTH-1:0] push_data;
  logic [2:0]                  occ_after;
  logic                        wr_fire;
  logic                        in_done;
  logic                        pop;
  logic                        rd_issue;
  logic                        issue_last;

  assign din_rdy    = (state_q == ST_IN);
  assign dout_vld   = (cnt_q != 2'd0);
  assign dout_last  = dout_vld & head_last_q;
  assign dout       = head_data_q;
  assign word_count = word_count_q;

  assign wr_fire    = din_vld & din_rdy;
  assign in_done    = wr_fire & (din_last | (wr_ptr_q == LAST_ADDR));
  assign pop        = dout_vld & dout_rdy;
  // Entries the skid buffer will hold after this edge; a read issued now
  // lands one cycle later, so it is only allowed while a slot stays free.
  assign occ_after  = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_issue   = (state_q == ST_OUT) && (rd_ptr_q < total_q) && (occ_after <= 3'd1);
  assign issue_last = (rd_ptr_q == (total_q - ONE_W));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic [DATA_WIDTH-1:0] rdata;

      deshift_lane_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .LANE      (gi)
      ) u_addr (
        .incr_i  (ByteRdIncr),
        .rd_ptr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
        .step_i  (ByteRdStep),
        .back_i  (RdBackStep),
        .total_i (total_q),
        .addr_o  (rd_addr),
        .zpad_o  (zpad_d[gi])
      );

      RAM_HS #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_ram (
        .clk    (clk),
        .we_i   (wr_fire),
        .waddr_i(wr_ptr_q),
        .wdata_i(din[gi*DATA_WIDTH +: DATA_WIDTH]),
        .re_i   (rd_issue),
        .raddr_i(rd_addr),
        .rdata_o(rdata)
      );

      assign push_data[gi*DATA_WIDTH +: DATA_WIDTH] = (ZPAD_EN && zpad_q[gi]) ? '0 : rdata;
    end
  endgenerate

  // Fill/drain FSM with write/read pointers and held-word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      total_q      <= '0;
      word_count_q <= '0;
    end else if (Rst) begin
      state_q      <= ST_IN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      total_q      <= '0;
      word_count_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + ONE_A;
        if (in_done) begin
          total_q <= {1'b0, wr_ptr_q} + ONE_W;
          state_q <= ST_OUT;
        end
      end
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + ONE_W;
      end
      if (pop && head_last_q) begin
        state_q  <= ST_IN;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end
      if (wr_fire) begin
        word_count_q <= word_count_q + ONE_W;
      end else if (pop) begin
        word_count_q <= word_count_q - ONE_W;
      end
    end
  end

  // Read-tag pipeline and two-entry output skid buffer (head drives dout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      zpad_q      <= '0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else if (Rst) begin
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      zpad_q      <= '0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_last_q <= issue_last;
        zpad_q    <= zpad_d;
      end
      case ({rd_vld_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_data_q <= push_data;
            head_last_q <= rd_last_q;
          end else begin
            tail_data_q <= push_data;
            tail_last_q <= rd_last_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          cnt_q       <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_data_q <= push_data;
            head_last_q <= rd_last_q;
          end else begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            tail_data_q <= push_data;
            tail_last_q <= rd_last_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deshift_buf.sv
// tb_deshift_buf: directed checks of fill, skewed drain, backpressure,
// overflow, synchronous clear and asynchronous reset.
module tb_deshift_buf;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            Rst = 1'b0;
  logic            ByteRdIncr = 1'b1;
  logic [AW-1:0]   ByteRdStep = 4'd1;
  logic [AW-1:0]   RdBackStep = 4'd4;
  logic [W*DW-1:0] din = '0;
  logic            din_vld = 1'b0;
  logic            din_last = 1'b0;
  logic            din_rdy;
  logic [W*DW-1:0] dout;
  logic            dout_vld;
  logic            dout_last;
  logic            dout_rdy = 1'b0;
  logic [AW:0]     word_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  deshift_buf #(
    .DATA_WIDTH(DW),
    .WIDTH     (W),
    .ADDR_WIDTH(AW),
    .DEPTH     (2**AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Rst       (Rst),
    .ByteRdIncr(ByteRdIncr),
    .ByteRdStep(ByteRdStep),
    .RdBackStep(RdBackStep),
    .din       (din),
    .din_vld   (din_vld),
    .din_last  (din_last),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_last (dout_last),
    .dout_rdy  (dout_rdy),
    .word_count(word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-derived expected beats: kind 0 incr step1/back4, kind 1 decrement
  // step1, kind 2 incr step2/back3 (M=6), kind 3 identity (step 0).
  function automatic logic [31:0] exp_beat(input int kind, input int r, input int base);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      int a;
      case (kind)
        0:       a = (r + i) % 4;
        1:       a = r - i;
        2:       a = (r + 2*i) % 6;
        default: a = r;
      endcase
      if (a >= 0) v[i*DW +: DW] = 8'(16*a + i + base);
    end
    return v;
  endfunction

  // Without zero padding the wrapped lanes of the decrement test are raw RAM.
  function automatic logic [31:0] lane_mask(input int kind, input int r);
    logic [31:0] m;
    m = '1;
`ifndef DESHIFT_ZPAD_EN
    if (kind == 1) begin
      for (int i = 0; i < W; i++) if (r - i < 0) m[i*DW +: DW] = '0;
    end
`endif
    return m;
  endfunction

  task automatic send(input int n, input bit with_last, input int base);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      check($sformatf("din_rdy_b%0d", b), din_rdy, 1);
      for (int i = 0; i < W; i++) din[i*DW +: DW] = 8'(16*b + i + base);
      din_vld  = 1'b1;
      din_last = with_last && (b == n - 1);
    end
    @(negedge clk);
    din_vld  = 1'b0;
    din_last = 1'b0;
    check("fill_count", word_count, n);
    check("din_rdy_out", din_rdy, 0);
    check("vld_early", dout_vld, 0);
  endtask

  task automatic drain(input int n_take, input int n_total, input int kind, input int base,
                       input bit toggle, output int cycles);
    int got = 0;
    int cyc = 0;
    int k = 0;
    logic [31:0] held = '0;
    bit stalled = 1'b0;
    while (got < n_take && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("stall_vld", dout_vld, 1);
        check("stall_data", dout, held);
      end
      dout_rdy = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      k++;
      stalled = 1'b0;
      if (dout_vld) begin
        if (dout_rdy) begin
          check($sformatf("data_k%0d_r%0d", kind, got), dout & lane_mask(kind, got),
                exp_beat(kind, got, base) & lane_mask(kind, got));
          check($sformatf("last_k%0d_r%0d", kind, got), dout_last, (got == n_total - 1));
          $display("beat kind=%0d r=%0d dout=%08h last=%0b", kind, got, dout, dout_last);
          got++;
        end else begin
          held = dout;
          stalled = 1'b1;
        end
      end
    end
    check("drain_count", got, n_take);
    cycles = cyc;
  endtask

  task automatic post_drain();
    @(negedge clk);
    dout_rdy = 1'b0;
    check("post_vld", dout_vld, 0);
    check("post_wc", word_count, 0);
    check("post_din_rdy", din_rdy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;

    // Reset values
    #12;
    check("rst_din_rdy", din_rdy, 1);
    check("rst_dout_vld", dout_vld, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_dout", dout, 0);
    check("rst_wc", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment mode, M=4, with latency and throughput checks
    ByteRdIncr = 1'b1; ByteRdStep = 4'd1; RdBackStep = 4'd4;
    send(4, 1'b1, 0);
    @(negedge clk);
    check("lat_1cyc", dout_vld, 0);
    @(negedge clk);
    check("lat_2cyc", dout_vld, 1);
    check("wc_full", word_count, 4);
    drain(4, 4, 0, 0, 1'b0, cyc);
    check("throughput", cyc, 4);
    post_drain();

    // Decrement mode, 8 beats
    ByteRdIncr = 1'b0; ByteRdStep = 4'd1;
    send(8, 1'b1, 0);
    drain(8, 8, 1, 0, 1'b0, cyc);
    post_drain();

    // Backpressure, M=6, ready pattern 1,0,0,1
    ByteRdIncr = 1'b1; ByteRdStep = 4'd2; RdBackStep = 4'd3;
    send(6, 1'b1, 0);
    drain(6, 6, 2, 0, 1'b1, cyc);
    post_drain();

    // Overflow: full DEPTH without last, step 0 (M=0 treated as DEPTH)
    ByteRdStep = 4'd0; RdBackStep = 4'd5;
    send(16, 1'b0, 0);
    drain(16, 16, 3, 0, 1'b0, cyc);
    post_drain();

    // Synchronous clear mid-drain, then a fresh frame
    send(4, 1'b1, 0);
    drain(3, 4, 3, 0, 1'b0, cyc);
    @(negedge clk);
    dout_rdy = 1'b0;
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    check("clr_vld", dout_vld, 0);
    check("clr_wc", word_count, 0);
    check("clr_din_rdy", din_rdy, 1);
    send(2, 1'b1, 8);
    drain(2, 2, 3, 8, 1'b0, cyc);
    post_drain();

    // Asynchronous reset pulse during fill
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) din[i*DW +: DW] = 8'(16*b + i + 4);
      din_vld = 1'b1;
    end
    @(negedge clk);
    din_vld = 1'b0;
    check("pre_pulse_wc", word_count, 2);
    rst_n = 1'b0;
    #1;
    check("pulse_din_rdy", din_rdy, 1);
    check("pulse_dout_vld", dout_vld, 0);
    check("pulse_dout_last", dout_last, 0);
    check("pulse_dout", dout, 0);
    check("pulse_wc", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 1'b1, 0);
    drain(2, 2, 3, 0, 1'b0, cyc);
    post_drain();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("no_extra_beat", dout_vld, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
